// File: rtl/vga_timing_receiver.sv
// VGA sync receiver: samples HS/VS/BLANK_N on pix_en, recovers RxX/RxY, locks to the frame
// timing and raises sticky timing errors. Define VGA_RX_ERR_COUNT_EN to add the err_count output.
module vga_timing_receiver #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_ACTIVE = 480
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        pix_en,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  input  logic        err_clr,
  output logic [9:0]  RxX,
  output logic [9:0]  RxY,
  output logic        rx_valid,
  output logic        locked,
  output logic        frame_start,
  output logic [15:0] frame_count,
  output logic        h_err,
  output logic        v_err
`ifdef VGA_RX_ERR_COUNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [9:0] HT_C = 10'(H_TOTAL);
  localparam logic [9:0] HS_C = 10'(H_SYNC);
  localparam logic [9:0] HA_C = 10'(H_ACTIVE);
  localparam logic [9:0] VT_C = 10'(V_TOTAL);
  localparam logic [9:0] VS_C = 10'(V_SYNC);
  localparam logic [9:0] VA_C = 10'(V_ACTIVE);

  state_t      state_q, state_d;
  logic        hs_q, vs_q;
  logic [9:0]  hcnt_q, xcnt_q, vcnt_q, ycnt_q, hslow_q, vslow_q, rxx_q, rxy_q;
  logic        acq_bad_q, acq_bad_d;
  logic        rx_valid_q, locked_q, frame_start_q, h_err_q, v_err_q;
  logic [15:0] frame_count_q;
  logic        hs_fall_s, hs_rise_s, vs_fall_s, vs_rise_s;
  logic        h_mis_s, v_mis_s, mis_s, count_frame_s;
  logic [9:0]  x_base_s, y_base_s;
`ifdef VGA_RX_ERR_COUNT_EN
  logic [7:0]  err_count_q;
`endif

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  // Edge detection, timing checks and next-state decode for the current pixel.
  always_comb begin
    hs_fall_s = hs_q & ~VGA_HS;
    hs_rise_s = ~hs_q & VGA_HS;
    vs_fall_s = vs_q & ~VGA_VS;
    vs_rise_s = ~vs_q & VGA_VS;
    h_mis_s   = (hs_fall_s && ((hcnt_q != HT_C) ||
                               ((xcnt_q != 10'd0) && (xcnt_q != HA_C)))) ||
                (hs_rise_s && (hslow_q != HS_C));
    v_mis_s   = (vs_fall_s && ((vcnt_q != VT_C) || (ycnt_q != VA_C))) ||
                (vs_rise_s && (vslow_q != VS_C));
    mis_s     = h_mis_s | v_mis_s;
    x_base_s  = hs_fall_s ? 10'd0 : xcnt_q;
    // A line counts as active once it delivered exactly H_ACTIVE visible pixels.
    y_base_s  = vs_fall_s ? 10'd0 :
                ((hs_fall_s && (xcnt_q == HA_C)) ? sat_inc10(ycnt_q) : ycnt_q);
    count_frame_s = (state_q == LOCKED) && vs_fall_s && !mis_s;
    state_d   = state_q;
    acq_bad_d = 1'b0;
    case (state_q)
      SEARCH: begin
        state_d = vs_fall_s ? ACQUIRE : SEARCH;
      end
      ACQUIRE: begin
        if (vs_fall_s) begin
          state_d = (acq_bad_q || mis_s) ? SEARCH : LOCKED;
        end else begin
          acq_bad_d = acq_bad_q | mis_s;
        end
      end
      LOCKED: begin
        state_d = mis_s ? SEARCH : LOCKED;
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // All receiver state; advances only on pixel strobes.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q       <= SEARCH;
      acq_bad_q     <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      hcnt_q        <= 10'd0;
      xcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      ycnt_q        <= 10'd0;
      hslow_q       <= 10'd0;
      vslow_q       <= 10'd0;
      rxx_q         <= 10'd0;
      rxy_q         <= 10'd0;
      rx_valid_q    <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 16'd0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
`ifdef VGA_RX_ERR_COUNT_EN
      err_count_q   <= 8'd0;
`endif
    end else if (pix_en) begin
      hs_q          <= VGA_HS;
      vs_q          <= VGA_VS;
      state_q       <= state_d;
      acq_bad_q     <= acq_bad_d;
      locked_q      <= (state_d == LOCKED);
      rx_valid_q    <= (state_d == LOCKED) && VGA_BLANK_N;
      frame_start_q <= vs_fall_s;
      hcnt_q        <= hs_fall_s ? 10'd1 : sat_inc10(hcnt_q);
      hslow_q       <= hs_fall_s ? 10'd1 : (!VGA_HS ? sat_inc10(hslow_q) : hslow_q);
      vcnt_q        <= vs_fall_s ? 10'd0 : (hs_fall_s ? sat_inc10(vcnt_q) : vcnt_q);
      vslow_q       <= vs_fall_s ? 10'd0 :
                       ((hs_fall_s && !VGA_VS) ? sat_inc10(vslow_q) : vslow_q);
      ycnt_q        <= y_base_s;
      if (VGA_BLANK_N) begin
        xcnt_q <= sat_inc10(x_base_s);
        rxx_q  <= x_base_s;
        rxy_q  <= y_base_s;
      end else begin
        xcnt_q <= x_base_s;
      end
      if (count_frame_s) begin
        frame_count_q <= frame_count_q + 16'd1;
      end else begin
        frame_count_q <= frame_count_q;
      end
      // A fresh mismatch beats a simultaneous clear.
      h_err_q <= (h_mis_s && (state_q != SEARCH)) ? 1'b1 : (err_clr ? 1'b0 : h_err_q);
      v_err_q <= (v_mis_s && (state_q != SEARCH)) ? 1'b1 : (err_clr ? 1'b0 : v_err_q);
`ifdef VGA_RX_ERR_COUNT_EN
      if (mis_s && (err_count_q != 8'd255)) begin
        err_count_q <= err_count_q + 8'd1;
      end else begin
        err_count_q <= err_count_q;
      end
`endif
    end else begin
      frame_start_q <= 1'b0;
    end
  end

  assign RxX         = rxx_q;
  assign RxY         = rxy_q;
  assign rx_valid    = rx_valid_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
`ifdef VGA_RX_ERR_COUNT_EN
  assign err_count   = err_count_q;
`endif

endmodule
